mem_arbiter: RTL

Shares one fixed-latency, word-wide data memory between the core's instruction-fetch port and its load/store port. Requesters use a req/ack handshake; the arbiter sequences each access through a small FSM, holds address and data stable for the memory's latency, and returns read data with a one-cycle ack. It sits between `mips_core`'s fetch/data sides and the memory model, and is the stall source for a multi-cycle core.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/lat_counter.sv | 30 +++
 rtl/mem_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch / load-store memory arbiter: FSM states, access owner and byte-lane word layout.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } arb_owner_t;

  typedef logic [7:0] byte_lane_t;
  // Lane 0 is the most significant byte of the word.
  typedef byte_lane_t [0:3] word_bytes_t;

endpackage

// File: rtl/lat_counter.sv
// Down-counter timing the ACCESS phase: loads MEM_LAT-1, decrements to 0 and holds; zero flag marks the last cycle.
// Latency: zero flag is decoded from the registered count; no backpressure.
module lat_counter #(
  parameter int MEM_LAT = 2
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);

  localparam int CW = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(MEM_LAT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency memory between fetch and load/store; data wins unless fetch has waited STARVE_LIM data grants.
// Request-to-ack is MEM_LAT+1 cycles; requesters stall by holding req until ack, and halted blocks only new grants.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_LIM = 3
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        halted,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_data,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  word_bytes_t d_wdata,
  output logic        d_ack,
  output word_bytes_t d_rdata,
  output logic [31:0] mem_addr,
  output word_bytes_t mem_data_in,
  input  word_bytes_t mem_data_out,
  output logic        mem_write_en,
  output logic        busy
);

  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

  arb_state_t  r_state;
  arb_state_t  w_state_nxt;
  arb_owner_t  r_owner;
  logic [31:0] r_addr;
  word_bytes_t r_wdata;
  logic        r_we;
  logic [SW-1:0] r_starve;
  logic [31:0] r_if_data;
  word_bytes_t r_d_rdata;

  logic w_grant;
  logic w_grant_if;
  logic w_lat_zero;
  logic w_last;

  always_comb begin
    w_grant    = 1'b0;
    w_grant_if = 1'b0;
    if ((r_state == IDLE) && !halted && (if_req || d_req)) begin
      w_grant    = 1'b1;
      w_grant_if = if_req && (!d_req || (r_starve == STARVE_MAX));
    end
  end

  lat_counter #(
    .MEM_LAT(MEM_LAT)
  ) u_lat (
    .clk   (clk),
    .i_rst (rst_b),
    .i_load(w_grant),
    .i_dec (r_state == ACCESS),
    .o_zero(w_lat_zero)
  );

  always_ff @(posedge clk) begin
    if (rst_b) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_last       = 1'b0;
    busy         = 1'b1;
    if_ack       = 1'b0;
    d_ack        = 1'b0;
    mem_write_en = 1'b0;
    unique case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (w_grant) w_state_nxt = ACCESS;
      end
      ACCESS: begin
        if (w_lat_zero) begin
          w_last       = 1'b1;
          mem_write_en = r_we;
          w_state_nxt  = RESP;
        end
      end
      RESP: begin
        if_ack      = (r_owner == OWN_IF);
        d_ack       = (r_owner == OWN_D);
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      r_owner   <= OWN_IF;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_we      <= 1'b0;
      r_starve  <= '0;
      r_if_data <= '0;
      r_d_rdata <= '0;
    end else begin
      if (w_grant) begin
        r_owner <= w_grant_if ? OWN_IF : OWN_D;
        r_addr  <= w_grant_if ? if_addr : d_addr;
        r_we    <= !w_grant_if && d_we;
        r_wdata <= w_grant_if ? '0 : d_wdata;
        // Only data grants that bypass a waiting fetch count towards starvation.
        if (w_grant_if || !if_req) begin
          r_starve <= '0;
        end else if (r_starve != STARVE_MAX) begin
          r_starve <= r_starve + SW'(1);
        end
      end
      if (w_last && !r_we) begin
        if (r_owner == OWN_IF) begin
          r_if_data <= mem_data_out;
        end else begin
          r_d_rdata <= mem_data_out;
        end
      end
    end
  end

  assign mem_addr    = r_addr;
  assign mem_data_in = r_wdata;
  assign if_data     = r_if_data;
  assign d_rdata     = r_d_rdata;

endmodule
